// File: rtl/i2c_tx_sched.sv
// I2C transmit transaction scheduler: sequences START+address, payload bytes from a
// show-ahead FIFO and a closing STOP command toward a byte engine, with ACK/underrun handling.
module i2c_tx_sched (
  input  logic       clock,
  input  logic       sclr,
  input  logic       go,
  input  logic [6:0] slave_addr,
  input  logic [3:0] byte_cnt,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rdreq,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_start,
  output logic       cmd_stop,
  output logic [7:0] cmd_byte,
  input  logic       ack_valid,
  input  logic       nack,
  output logic       busy,
  output logic       done,
  output logic       err_nack,
  output logic       err_underrun,
  output logic [4:0] sent_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT_ACK,
    DATA,
    STOP
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [4:0] rem_q, rem_d;
  logic [4:0] sent_q, sent_d;
  logic       nack_flag_q, nack_flag_d;
  logic       under_flag_q, under_flag_d;
  logic       armed_q, armed_d;
  logic [7:0] byte_q, byte_d;
  logic       done_q, done_d;
  logic       err_nack_q, err_nack_d;
  logic       err_under_q, err_under_d;

  always_ff @(posedge clock or negedge sclr) begin
    if (!sclr) begin
      state_q      <= IDLE;
      addr_q       <= 7'd0;
      rem_q        <= 5'd0;
      sent_q       <= 5'd0;
      nack_flag_q  <= 1'b0;
      under_flag_q <= 1'b0;
      armed_q      <= 1'b0;
      byte_q       <= 8'h00;
      done_q       <= 1'b0;
      err_nack_q   <= 1'b0;
      err_under_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      sent_q       <= sent_d;
      nack_flag_q  <= nack_flag_d;
      under_flag_q <= under_flag_d;
      armed_q      <= armed_d;
      byte_q       <= byte_d;
      done_q       <= done_d;
      err_nack_q   <= err_nack_d;
      err_under_q  <= err_under_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    sent_d       = sent_q;
    nack_flag_d  = nack_flag_q;
    under_flag_d = under_flag_q;
    armed_d      = armed_q;
    byte_d       = byte_q;
    done_d       = 1'b0;
    err_nack_d   = 1'b0;
    err_under_d  = 1'b0;
    cmd_valid    = 1'b0;
    cmd_start    = 1'b0;
    cmd_stop     = 1'b0;
    cmd_byte     = 8'h00;
    fifo_rdreq   = 1'b0;

    case (state_q)
      IDLE: begin
        if (go) begin
          addr_d       = slave_addr;
          rem_d        = {1'b0, byte_cnt} + 5'd1;
          sent_d       = 5'd0;
          nack_flag_d  = 1'b0;
          under_flag_d = 1'b0;
          armed_d      = 1'b0;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        cmd_valid = 1'b1;
        cmd_start = 1'b1;
        cmd_byte  = {addr_q, 1'b0};
        if (cmd_ready) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_valid) begin
          armed_d = 1'b0;
          if (nack) begin
            nack_flag_d = 1'b1;
            state_d     = STOP;
          end else if (rem_q == 5'd0) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        // Emptiness only matters before the command is raised; afterwards the
        // captured byte is held so the command stays stable until transfer.
        if (!armed_q && fifo_empty) begin
          under_flag_d = 1'b1;
          state_d      = STOP;
        end else begin
          cmd_valid = 1'b1;
          cmd_byte  = armed_q ? byte_q : fifo_q;
          if (!armed_q) begin
            armed_d = 1'b1;
            byte_d  = fifo_q;
          end
          if (cmd_ready) begin
            fifo_rdreq = !fifo_empty;
            rem_d      = rem_q - 5'd1;
            sent_d     = sent_q + 5'd1;
            armed_d    = 1'b0;
            state_d    = WAIT_ACK;
          end
        end
      end
      STOP: begin
        cmd_valid = 1'b1;
        cmd_stop  = 1'b1;
        if (cmd_ready) begin
          done_d       = 1'b1;
          err_nack_d   = nack_flag_q;
          err_under_d  = under_flag_q;
          nack_flag_d  = 1'b0;
          under_flag_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err_nack     = err_nack_q;
  assign err_underrun = err_under_q;
  assign sent_cnt     = sent_q;

endmodule

// File: tb/tb_i2c_tx_sched.sv
// Directed bench for i2c_tx_sched: behavioural show-ahead FIFO and byte engine,
// command log compared against hand-computed sequences.
module tb_i2c_tx_sched;

  logic       clock = 1'b0;
  logic       sclr;
  logic       go;
  logic [6:0] slave_addr;
  logic [3:0] byte_cnt;
  logic       fifo_empty;
  logic [7:0] fifo_q;
  logic       fifo_rdreq;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_stop;
  logic [7:0] cmd_byte;
  logic       ack_valid;
  logic       nack;
  logic       busy;
  logic       done;
  logic       err_nack;
  logic       err_underrun;
  logic [4:0] sent_cnt;

  always #5 clock = ~clock;

  i2c_tx_sched dut (
    .clock        (clock),
    .sclr         (sclr),
    .go           (go),
    .slave_addr   (slave_addr),
    .byte_cnt     (byte_cnt),
    .fifo_empty   (fifo_empty),
    .fifo_q       (fifo_q),
    .fifo_rdreq   (fifo_rdreq),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cmd_byte     (cmd_byte),
    .ack_valid    (ack_valid),
    .nack         (nack),
    .busy         (busy),
    .done         (done),
    .err_nack     (err_nack),
    .err_underrun (err_underrun),
    .sent_cnt     (sent_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] fifo_mem[$];
  logic [9:0] log_q[$];
  logic [9:0] exp_q[$];
  logic [31:0] nack_plan;
  int rdreq_cnt;

  function automatic logic [9:0] c_start(input logic [7:0] b); return {2'b10, b}; endfunction
  function automatic logic [9:0] c_data(input logic [7:0] b);  return {2'b00, b}; endfunction
  function automatic logic [9:0] c_stop();                     return {2'b01, 8'h00}; endfunction

  task automatic refresh_fifo();
    fifo_empty = (fifo_mem.size() == 0);
    fifo_q     = fifo_empty ? 8'h00 : fifo_mem[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem.push_back(b);
    refresh_fifo();
  endtask

  task automatic flush();
    fifo_mem.delete();
    refresh_fifo();
  endtask

  // Byte engine + FIFO: samples the handshake just before the edge, acts just after it.
  logic       eng_x, eng_p;
  logic [9:0] eng_ent;
  int         eng_idx;
  initial begin
    ack_valid = 1'b0;
    nack      = 1'b0;
    forever begin
      @(negedge clock);
      #4;
      eng_x   = cmd_valid && cmd_ready && sclr;
      eng_p   = fifo_rdreq && sclr;
      eng_ent = {cmd_start, cmd_stop, cmd_byte};
      if (fifo_rdreq) check_eq("rdreq_while_empty", fifo_empty, 0);
      @(posedge clock);
      #1;
      ack_valid = 1'b0;
      nack      = 1'b0;
      if (eng_p && fifo_mem.size() > 0) begin
        void'(fifo_mem.pop_front());
        rdreq_cnt++;
        refresh_fifo();
      end
      if (eng_x) begin
        eng_idx = log_q.size();
        log_q.push_back(eng_ent);
        if (!eng_ent[8]) begin
          ack_valid = 1'b1;
          nack      = nack_plan[eng_idx];
        end
      end
    end
  end

  task automatic prep();
    log_q.delete();
    exp_q.delete();
    rdreq_cnt = 0;
    nack_plan = '0;
  endtask

  task automatic start_txn(input logic [6:0] a, input logic [3:0] c);
    @(negedge clock);
    go         = 1'b1;
    slave_addr = a;
    byte_cnt   = c;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      @(negedge clock);
    end
    check_eq({tag, "_done"}, done, 1);
  endtask

  task automatic wait_log(input string tag, input int n);
    for (int i = 0; i < 100; i++) begin
      if (log_q.size() >= n) break;
      @(negedge clock);
    end
    check_eq({tag, "_log_reached"}, log_q.size(), n);
  endtask

  task automatic compare_log(input string tag);
    check_eq({tag, "_log_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check_eq($sformatf("%s_cmd%0d", tag, i), log_q[i], exp_q[i]);
  endtask

  task automatic check_end(input string tag, input int en, input int eu, input int sc,
                           input int rd, input int fl);
    check_eq({tag, "_err_nack"}, err_nack, en);
    check_eq({tag, "_err_underrun"}, err_underrun, eu);
    check_eq({tag, "_sent_cnt"}, sent_cnt, sc);
    check_eq({tag, "_rdreq_cnt"}, rdreq_cnt, rd);
    check_eq({tag, "_fifo_left"}, fifo_mem.size(), fl);
    compare_log(tag);
    $display("txn %s: cmds=%0d sent=%0d rdreq=%0d fifo_left=%0d", tag, log_q.size(),
             sent_cnt, rdreq_cnt, fifo_mem.size());
  endtask

  initial begin
    sclr       = 1'b0;
    go         = 1'b0;
    slave_addr = 7'd0;
    byte_cnt   = 4'd0;
    cmd_ready  = 1'b1;
    flush();
    prep();
    repeat (3) @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_rdreq", fifo_rdreq, 0);
    check_eq("rst_sent_cnt", sent_cnt, 0);
    check_eq("rst_errs", {err_nack, err_underrun}, 0);
    sclr = 1'b1;
    @(negedge clock);
    check_eq("idle_cmd_valid", cmd_valid, 0);

    // Normal 3-byte write
    push(8'hA1); push(8'hB2); push(8'hC3);
    prep();
    exp_q = '{c_start(8'hA0), c_data(8'hA1), c_data(8'hB2), c_data(8'hC3), c_stop()};
    start_txn(7'h50, 4'd2);
    check_eq("t1_busy", busy, 1);
    wait_done("t1");
    check_end("t1", 0, 0, 3, 3, 0);
    @(negedge clock);
    check_eq("t1_done_one_cycle", done, 0);
    check_eq("t1_idle_busy", busy, 0);
    repeat (3) @(negedge clock);
    check_eq("t1_sent_hold", sent_cnt, 3);

    // Address NACK
    flush(); push(8'h11); push(8'h22);
    prep();
    nack_plan[0] = 1'b1;
    exp_q = '{c_start(8'h54), c_stop()};
    start_txn(7'h2A, 4'd1);
    wait_done("t2");
    check_end("t2", 1, 0, 0, 0, 2);

    // NACK on second data byte
    flush(); push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    prep();
    nack_plan[2] = 1'b1;
    exp_q = '{c_start(8'h24), c_data(8'hD1), c_data(8'hD2), c_stop()};
    start_txn(7'h12, 4'd3);
    wait_done("t3");
    check_end("t3", 1, 0, 2, 2, 2);

    // FIFO underrun
    flush(); push(8'hE1);
    prep();
    exp_q = '{c_start(8'h66), c_data(8'hE1), c_stop()};
    start_txn(7'h33, 4'd3);
    wait_done("t4");
    check_end("t4", 0, 1, 1, 1, 0);

    // Back-pressure in DATA plus go while busy
    flush(); push(8'h5A);
    prep();
    exp_q = '{c_start(8'h02), c_data(8'h5A), c_stop()};
    start_txn(7'h01, 4'd0);
    wait_log("t5", 1);
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_eq($sformatf("t5_stall_valid%0d", k), cmd_valid, 1);
      check_eq($sformatf("t5_stall_byte%0d", k), cmd_byte, 8'h5A);
      check_eq($sformatf("t5_stall_rdreq%0d", k), fifo_rdreq, 0);
      if (k == 1) begin
        go = 1'b1; slave_addr = 7'h44; byte_cnt = 4'd5;
      end
      if (k == 2) go = 1'b0;
    end
    cmd_ready = 1'b1;
    wait_done("t5");
    check_end("t5", 0, 0, 1, 1, 0);
    repeat (4) @(negedge clock);
    check_eq("t5_go_ignored_busy", busy, 0);
    check_eq("t5_go_ignored_log", log_q.size(), 3);

    // Reset while DATA command is pending
    flush(); push(8'h77); push(8'h88);
    prep();
    start_txn(7'h7F, 4'd1);
    wait_log("t6", 2);
    cmd_ready = 1'b0;
    @(negedge clock);
    check_eq("t6_pre_valid", cmd_valid, 1);
    check_eq("t6_pre_sent", sent_cnt, 1);
    sclr      = 1'b0;
    cmd_ready = 1'b1;
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_valid", cmd_valid, 0);
    check_eq("t6_rst_rdreq", fifo_rdreq, 0);
    check_eq("t6_rst_sent", sent_cnt, 0);
    check_eq("t6_rst_start_stop", {cmd_start, cmd_stop}, 0);
    check_eq("t6_rst_done_err", {done, err_nack, err_underrun}, 0);
    @(negedge clock);
    sclr = 1'b1;
    @(negedge clock);
    check_eq("t6_fifo_left", fifo_mem.size(), 1);
    check_eq("t6_rdreq_cnt", rdreq_cnt, 1);
    check_eq("t6_idle_busy", busy, 0);
    $display("txn t6: reset mid-DATA, cmds=%0d fifo_left=%0d", log_q.size(), fifo_mem.size());

    // First transaction after reset
    push(8'h99);
    prep();
    exp_q = '{c_start(8'hFE), c_data(8'h88), c_data(8'h99), c_stop()};
    start_txn(7'h7F, 4'd1);
    wait_done("t7");
    check_end("t7", 0, 0, 2, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_tx_sched.md
I2C_TX_SCHED -- requirements
Module: i2c_tx_sched

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as follows:
- clock  in  1  rising-edge clock
- sclr  in  1  asynchronous active-low reset
REQ-002 SHALL provide the following ports:
- go  in  1  single-cycle transaction start request
- slave_addr  in  7  target address, latched on accepted go
- byte_cnt  in  4  number of payload bytes minus 1 (1..16 bytes), latched on accepted go
- fifo_empty  in  1  tx FIFO empty flag
- fifo_q  in  8  tx FIFO head byte, show-ahead (valid while !fifo_empty)
- fifo_rdreq  out  1  pop tx FIFO head
- cmd_valid  out  1  command to byte engine valid
- cmd_ready  in  1  byte engine accepts command
- cmd_start  out  1  command carries START before byte
- cmd_stop  out  1  command is STOP only
- cmd_byte  out  8  byte to transmit
- ack_valid  in  1  byte engine reports slave ACK bit
- nack  in  1  slave NACK, qualified by ack_valid
- busy  out  1  transaction in progress
- done  out  1  one-cycle end-of-transaction pulse
- err_nack  out  1  one-cycle pulse with done; transaction NACKed
- err_underrun  out  1  one-cycle pulse with done; FIFO ran dry
- sent_cnt  out  5  payload bytes accepted by engine in current/last transaction

Function
REQ-003 SHALL implement FSM states IDLE, ADDR, WAIT_ACK, DATA, STOP.
REQ-004 Handshake: a command transfers on a cycle with cmd_valid=1 and cmd_ready=1; once raised, cmd_valid and cmd_* SHALL hold stable until that transfer.
REQ-005 IDLE: busy=0, cmd_valid=0; go=1 latches slave_addr, rem=byte_cnt+1, clears sent_cnt, enters ADDR next cycle with busy=1.
REQ-006 go while busy=1 SHALL be ignored with no effect.
REQ-007 ADDR: cmd_valid=1, cmd_start=1, cmd_stop=0, cmd_byte={slave_addr,1'b0}; on transfer -> WAIT_ACK.
REQ-008 WAIT_ACK: cmd_valid=0; on ack_valid: nack=1 -> STOP with NACK flag set; else rem=0 -> STOP; else -> DATA.
REQ-009 ack_valid outside WAIT_ACK SHALL be ignored.
REQ-010 DATA, first cycle: fifo_empty=1 -> STOP with underrun flag set, nothing popped; else cmd_valid=1, cmd_start=0, cmd_byte=fifo_q.
REQ-011 DATA transfer cycle: fifo_rdreq=1 for exactly that cycle (combinational from handshake); rem decrements, sent_cnt increments; -> WAIT_ACK.
REQ-012 fifo_rdreq SHALL never assert outside DATA transfer cycles and never while fifo_empty=1.
REQ-013 STOP: cmd_valid=1, cmd_stop=1, cmd_start=0, cmd_byte=8'h00; on transfer -> IDLE.
REQ-014 On the clock edge after STOP transfer: done=1 for one cycle, busy=0, err_nack/err_underrun pulse per latched flag, flags cleared.
REQ-015 After NACK or underrun, remaining FIFO bytes SHALL stay unpopped.
REQ-016 sent_cnt SHALL hold its final value in IDLE until next accepted go; max value 16.
REQ-017 cmd_start and cmd_stop SHALL never be 1 simultaneously; both 0 when cmd_valid=0.

Reset
REQ-018 sclr=0 SHALL asynchronously force IDLE, busy=0, done=0, err_*=0, cmd_valid=0, fifo_rdreq=0, sent_cnt=0, rem=0, flags cleared, from any state including mid-handshake.
REQ-019 After sclr release, first accepted go SHALL behave exactly as REQ-005.

Verification
REQ-020 addr=7'h50, byte_cnt=2, FIFO {A1,B2,C3}, all ACK, cmd_ready=1 -> cmd_byte sequence A0(start),A1,B2,C3,00(stop); 3 rdreq pulses; done, sent_cnt=3, no err.
REQ-021 addr NACK -> STOP immediately, done+err_nack, sent_cnt=0, FIFO untouched.
REQ-022 byte_cnt=3, NACK on 2nd data byte -> STOP after it, done+err_nack, sent_cnt=2, 2 bytes left in FIFO.
REQ-023 byte_cnt=3, FIFO holds 1 byte -> second DATA sees empty, STOP, done+err_underrun, sent_cnt=1.
REQ-024 cmd_ready low 5 cycles in DATA, go pulsed while busy -> cmd_byte stable, single rdreq, second go ignored.
REQ-025 sclr asserted while cmd_valid=1 in DATA -> all outputs reset values within same cycle, no rdreq.
